score_digit_converter: RTL and testbench

Sequential binary-to-BCD converter that feeds the transparent number-sprite renderers. It accepts a binary score via a valid/ready handshake and converts it with a one-bit-per-cycle double-dabble. The result is held in a pending register and committed to the displayed digits only on a frame-start strobe, so digit sprites never change mid-frame. Each 4-bit digit output drives the `number` input of one digit sprite instance, and each digit enable gates that sprite's `draw_out`.

---
 rtl/score_pkg.sv | 21 ++
 rtl/dabble_step.sv | 17 +
 rtl/score_digit_converter.sv | 105 ++++++++++
 tb/tb_score_digit_converter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types, constants and helpers for the score BCD converter
package score_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DIGIT_W = 4;

    // Largest value representable in n decimal digits (10^n - 1)
    function automatic int max_val(input int n);
        int v;
        v = 1;
        for (int i = 0; i < n; i++) v = v * 10;
        return v - 1;
    endfunction

    // Blanking helper: a digit keeps its sprite enabled when it is nonzero
    function automatic logic nz(input logic [DIGIT_W-1:0] d);
        return |d;
    endfunction

endpackage

// File: rtl/dabble_step.sv
// dabble_step: add 3 to every BCD nibble that is 5 or more before the shift
module dabble_step
    import score_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] bcd_in,
    output logic [WIDTH-1:0] bcd_out
);

    for (genvar i = 0; i < WIDTH / DIGIT_W; i++) begin : g_nib
        assign bcd_out[i*DIGIT_W +: DIGIT_W] = (bcd_in[i*DIGIT_W +: DIGIT_W] >= 4'd5)
            ? bcd_in[i*DIGIT_W +: DIGIT_W] + 4'd3
            : bcd_in[i*DIGIT_W +: DIGIT_W];
    end

endmodule

// File: rtl/score_digit_converter.sv
// score_digit_converter: sequential binary-to-BCD with frame-aligned digit commit
module score_digit_converter
    import score_pkg::*;
#(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                          pixel_clk_in,
    input  logic                          rst_in,
    input  logic [BIN_WIDTH-1:0]          score_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          new_frame_in,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]         digit_en_out,
    output logic                          busy_out
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] MAX_VAL = 32'(max_val(NUM_DIGITS));
    localparam logic [BIN_WIDTH-1:0] CLAMP = BIN_WIDTH'(MAX_VAL);

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt;
    logic [BCD_W-1:0]       bcd, bcd_adj, pending, commit_src;
    logic [BIN_WIDTH-1:0]   bin_sh;
    logic                   pending_valid;
    logic [NUM_DIGITS-1:0]  en_nx;
    logic                   any_nz;

    dabble_step #(.WIDTH(BCD_W)) u_step (
        .bcd_in  (bcd),
        .bcd_out (bcd_adj)
    );

    assign ready_out = (state == IDLE);
    assign busy_out  = (state != IDLE);

    // FSM state register
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    // FSM next state: accept, BIN_WIDTH shift iterations, one DONE cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (valid_in) state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_WIDTH - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Conversion datapath: clamp-and-load on accept, add-3 then shift while in SHIFT
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt    <= '0;
            bcd    <= '0;
            bin_sh <= '0;
        end else if (state == IDLE && valid_in) begin
            cnt    <= '0;
            bcd    <= '0;
            bin_sh <= (32'(score_in) > MAX_VAL) ? CLAMP : score_in;
        end else if (state == SHIFT) begin
            cnt           <= cnt + CNT_W'(1);
            {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
        end
    end

    // Leading-zero blanking of whichever value is about to be committed
    always_comb begin
        commit_src = (state == DONE) ? bcd : pending;
        any_nz     = 1'b0;
        en_nx      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            any_nz   = any_nz | nz(commit_src[i*DIGIT_W +: DIGIT_W]);
            en_nx[i] = any_nz | (i == 0);
        end
    end

    // Pending hold and frame-start commit; a DONE coinciding with the strobe commits directly
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            digits_out    <= '0;
            digit_en_out  <= NUM_DIGITS'(1);
        end else begin
            if (state == DONE) begin
                pending       <= bcd;
                pending_valid <= !new_frame_in;
            end else if (new_frame_in && pending_valid) begin
                pending_valid <= 1'b0;
            end
            if (new_frame_in && (state == DONE || pending_valid)) begin
                digits_out   <= commit_src;
                digit_en_out <= en_nx;
            end
        end
    end

endmodule

// File: tb/tb_score_digit_converter.sv
// tb_score_digit_converter: directed self-checking bench for score_digit_converter
module tb_score_digit_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        nf = 1'b0;
    logic [13:0] score = '0;
    logic        ready, busy;
    logic [15:0] digits;
    logic [3:0]  en;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    score_digit_converter #(.BIN_WIDTH(14), .NUM_DIGITS(4)) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .score_in     (score),
        .valid_in     (valid),
        .ready_out    (ready),
        .new_frame_in (nf),
        .digits_out   (digits),
        .digit_en_out (en),
        .busy_out     (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe;
        nf = 1'b1;
        tick;
        nf = 1'b0;
    endtask

    task automatic convert(input logic [13:0] s);
        int n;
        n = 0;
        while (!ready && n < 50) begin tick; n++; end
        score = s;
        valid = 1'b1;
        tick;
        valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!ready && n < 40) begin tick; n++; end
        chk("accept_to_ready", 32'(n), 32'd15);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 32'(digits), 32'h0000);
        chk("rst_en", 32'(en), 32'b0001);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (3) tick;
        chk("idle_digits", 32'(digits), 32'h0000);
        chk("idle_en", 32'(en), 32'b0001);
        chk("idle_ready", 32'(ready), 32'd1);

        convert(14'd1234);
        chk("1234_hold_digits", 32'(digits), 32'h0000);
        repeat (4) tick;
        chk("1234_prestrobe_digits", 32'(digits), 32'h0000);
        chk("1234_prestrobe_en", 32'(en), 32'b0001);
        strobe;
        chk("1234_digits", 32'(digits), 32'h1234);
        chk("1234_en", 32'(en), 32'b1111);

        convert(14'd7);
        strobe;
        chk("7_digits", 32'(digits), 32'h0007);
        chk("7_en", 32'(en), 32'b0001);

        convert(14'd0);
        strobe;
        chk("0_digits", 32'(digits), 32'h0000);
        chk("0_en", 32'(en), 32'b0001);

        convert(14'd1005);
        strobe;
        chk("1005_digits", 32'(digits), 32'h1005);
        chk("1005_en", 32'(en), 32'b1111);

        score = 14'd12000;
        valid = 1'b1;
        tick;
        n = 0;
        repeat (3) begin
            score = 14'd5;
            valid = 1'b1;
            tick;
            n++;
            chk("busy_ignores_valid_ready", 32'(ready), 32'd0);
        end
        valid = 1'b0;
        while (!ready && n < 40) begin tick; n++; end
        chk("12000_latency", 32'(n), 32'd15);
        tick;
        chk("no_restart_after_pulses", 32'(busy), 32'd0);
        strobe;
        chk("clamp_digits", 32'(digits), 32'h9999);
        chk("clamp_en", 32'(en), 32'b1111);

        convert(14'd42);
        convert(14'd517);
        chk("overwrite_prestrobe", 32'(digits), 32'h9999);
        strobe;
        chk("overwrite_digits", 32'(digits), 32'h0517);
        chk("overwrite_en", 32'(en), 32'b0111);

        score = 14'd88;
        valid = 1'b1;
        tick;
        valid = 1'b0;
        repeat (14) tick;
        chk("88_in_done_busy", 32'(busy), 32'd1);
        chk("88_before_commit", 32'(digits), 32'h0517);
        strobe;
        chk("88_direct_digits", 32'(digits), 32'h0088);
        chk("88_direct_en", 32'(en), 32'b0011);
        chk("88_ready", 32'(ready), 32'd1);
        repeat (2) tick;
        strobe;
        chk("88_empty_strobe_digits", 32'(digits), 32'h0088);
        chk("88_empty_strobe_en", 32'(en), 32'b0011);

        convert(14'd56);
        strobe;
        chk("56_digits", 32'(digits), 32'h0056);
        chk("56_en", 32'(en), 32'b0011);

        score = 14'd4321;
        valid = 1'b1;
        tick;
        valid = 1'b0;
        repeat (5) tick;
        chk("4321_busy_midshift", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_digits", 32'(digits), 32'h0000);
        chk("async_rst_en", 32'(en), 32'b0001);
        chk("async_rst_ready", 32'(ready), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        #2;
        rst = 1'b1;
        tick;
        strobe;
        chk("post_rst_strobe_digits", 32'(digits), 32'h0000);
        chk("post_rst_strobe_en", 32'(en), 32'b0001);

        convert(14'd9);
        strobe;
        chk("9_digits", 32'(digits), 32'h0009);
        chk("9_en", 32'(en), 32'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
